vga_axil_native_bridge: RTL and testbench
=========================================

// Module: vga_axil_native_bridge
// PURPOSE
//  Parametrised AXI4-Lite slave that converts AXI-Lite transactions into a native register-file port.
//  Native port: separate rd/wr address, 1-cycle strobes, configurable read latency.
//  Adds range decode with DECERR, independent concurrent rd/wr channels and byte enables.
//  Sits between the VGA AXI-Lite interconnect and the VGA control/status register block.
// PARAMETERS
//  AXIL_ADDR_W    32      AXI-Lite address width
//  AXIL_DATA_W    32      data width; 32 or 64 only
//  NATIVE_ADDR_W  8       native word-address width
//  BASE_ADDR      'h0     byte base of the window; aligned to window size
//  READ_LATENCY   1       cycles from read_en_o to valid data_i; 0..7
// PORTS
//  clk_i             in   1              clock
//  arst_i            in   1              asynchronous reset, active-high
//  awaddr/awvalid/awready  in/in/out   AXIL_ADDR_W/1/1   write-address channel
//  wdata/wstrb/wvalid/wready  in/in/in/out  AXIL_DATA_W/AXIL_DATA_W/8/1/1   write-data channel
//  bresp/bvalid/bready  out/out/in  2/1/1   write-response channel
//  araddr/arvalid/arready  in/in/out   AXIL_ADDR_W/1/1   read-address channel
//  rdata/rresp/rvalid/rready  out/out/out/in  AXIL_DATA_W/2/1/1   read-data channel
//  write_en_o        out  1              native write strobe, 1 cycle
//  addr_write_o      out  NATIVE_ADDR_W  native write word address
//  data_o            out  AXIL_DATA_W    native write data
//  strb_o            out  AXIL_DATA_W/8  native byte enables
//  read_en_o         out  1              native read strobe, 1 cycle
//  addr_read_o       out  NATIVE_ADDR_W  native read word address
//  data_i            in   AXIL_DATA_W    native read data
// BEHAVIOUR
//  Reset:
//   - All valid/ready/strobe outputs are 0; bresp/rresp = OKAY; addr/data/rdata = 0.
//   - Both FSMs go to IDLE; in-flight transactions are dropped, with no response.
//  Range decode:
//   - In range iff BASE_ADDR <= addr < BASE_ADDR + 2**NATIVE_ADDR_W*(AXIL_DATA_W/8).
//   - native addr = (addr-BASE_ADDR) >> log2(AXIL_DATA_W/8); low byte bits are ignored.
//  Write FSM: W_IDLE -> W_STROBE -> W_RESP -> W_IDLE.
//   - In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured.
//   - AW and W are accepted in either order or in the same cycle.
//   - After both are captured -> W_STROBE (1 cycle): write_en_o=1 only if in range, else DECERR.
//   - W_RESP: bvalid=1 and bresp held stable until bready; then -> W_IDLE.
//   - Latency: AW+W handshake at cycle T -> write_en_o at T+1 -> bvalid at T+2.
//  Read FSM: R_IDLE -> R_STROBE -> R_WAIT -> R_RESP -> R_IDLE.
//   - arready=1 only in R_IDLE.
//   - R_STROBE: read_en_o=1 if in range; addr_read_o is held until R_RESP.
//   - R_WAIT counts READ_LATENCY cycles, then rdata <= data_i; 0 skips R_WAIT and samples in R_STROBE.
//   - Out of range: no read_en_o, rdata=0, rresp=DECERR, wait skipped.
//   - R_RESP: rvalid=1 with rdata/rresp stable until rready.
//   - Latency: AR at T -> read_en_o at T+1 -> rvalid at T+2+READ_LATENCY.
//  Channel rules:
//   - Channels are independent; simultaneous write_en_o and read_en_o are legal, including to the same address.
//   - No combinational path from any valid to any ready.
//   - bready/rready held high -> the next transaction is accepted the cycle after the response handshake.
//  Reset asserted mid-transaction: strobes drop asynchronously.
//  Reset release: FSMs resume from IDLE.
// CONFIGURATION
//  VGA_AXIL_WSTRB_EN defined:
//   - strb_o = captured wstrb; any wstrb, including 0, gives OKAY; the native side applies byte enables.
//  Not defined:
//   - strb_o tied all-ones.
//   - wstrb != all-ones -> no write_en_o, bresp=SLVERR.
// STRUCTURE
//  vga_axil_pkg:
//   - axil_resp_e {OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3}
//   - axil_wr_state_e, axil_rd_state_e
//   - addr_in_range() function
//  Sub-module vga_axil_rd_channel: read FSM plus latency counter.
//  The write FSM stays in the top.
// TESTING
//  Back-to-back write then read, 10 random in-range addrs, READ_LATENCY=1
//   -> data matches, all OKAY, bvalid at T+2.
//  W before AW by 3 cycles, addr BASE+'h8, data 'hDEADBEEF
//   -> one write_en_o, addr_write_o=2, bresp OKAY.
//  Read at BASE+window size
//   -> no read_en_o, rresp=DECERR, rdata=0.
//  Write at BASE+window size -> no write_en_o, bresp=DECERR.
//  READ_LATENCY=3, AR at T -> rvalid at T+5.
//  READ_LATENCY=3, rready low 4 cycles -> rdata stable until handshake.
//  wstrb='b0011, data 'h1234_5678
//   -> macro on: strb_o='b0011, OKAY.
//   -> macro off: no write_en_o, SLVERR.
//  arst_i pulsed while bvalid=1 -> bvalid=0 immediately.
//  arst_i release: next write completes OKAY.

Source files
------------

// File: rtl/vga_axil_pkg.sv
// Shared types and helpers for the VGA AXI4-Lite to native register bridge.
package vga_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_STROBE,
    W_RESP
  } axil_wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STROBE,
    R_WAIT,
    R_RESP
  } axil_rd_state_e;

  // True when a byte address falls inside [base, base + win_bytes).
  // Widened to 64 bits so a window reaching the top of the address space
  // does not wrap.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] win_bytes);
    return (addr >= base) && ((addr - base) < win_bytes);
  endfunction

endpackage

// File: rtl/vga_axil_rd_channel.sv
// Read side of the bridge: AR capture, range decode, native read strobe,
// READ_LATENCY wait and R response hold.
module vga_axil_rd_channel
  import vga_axil_pkg::*;
#(
  parameter int unsigned              AXIL_ADDR_W   = 32,
  parameter int unsigned              AXIL_DATA_W   = 32,
  parameter int unsigned              NATIVE_ADDR_W = 8,
  parameter logic [AXIL_ADDR_W-1:0]   BASE_ADDR     = '0,
  parameter int unsigned              READ_LATENCY  = 1
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [AXIL_ADDR_W-1:0]   araddr_i,
  input  logic                     arvalid_i,
  output logic                     arready_o,
  output logic [AXIL_DATA_W-1:0]   rdata_o,
  output logic [1:0]               rresp_o,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  output logic                     read_en_o,
  output logic [NATIVE_ADDR_W-1:0] addr_read_o,
  input  logic [AXIL_DATA_W-1:0]   data_i
);

  localparam int unsigned BYTE_SH   = (AXIL_DATA_W == 64) ? 3 : 2;
  localparam logic [63:0] WIN_BYTES = 64'd1 << (NATIVE_ADDR_W + BYTE_SH);
  // The wait state is entered one cycle after the strobe, so it lasts
  // READ_LATENCY cycles with the counter running down to zero.
  localparam logic [2:0]  WAIT_INIT = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);

  axil_rd_state_e           state_q, state_d;
  logic                     live_q;
  logic [NATIVE_ADDR_W-1:0] raddr_q, raddr_d;
  logic                     rrange_q, rrange_d;
  logic [AXIL_DATA_W-1:0]   rdata_q, rdata_d;
  axil_resp_e               rresp_q, rresp_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     ar_hs;

  assign arready_o   = live_q && (state_q == R_IDLE);
  assign ar_hs       = arvalid_i && arready_o;
  assign read_en_o   = (state_q == R_STROBE) && rrange_q;
  assign rvalid_o    = (state_q == R_RESP);
  assign addr_read_o = raddr_q;
  assign rdata_o     = rdata_q;
  assign rresp_o     = rresp_q;

  // Next-state logic for the read FSM and its latency counter.
  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    rrange_d = rrange_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d  = NATIVE_ADDR_W'((araddr_i - BASE_ADDR) >> BYTE_SH);
          rrange_d = addr_in_range(64'(araddr_i), 64'(BASE_ADDR), WIN_BYTES);
          state_d  = R_STROBE;
        end
      end
      R_STROBE: begin
        if (!rrange_q) begin
          rdata_d = '0;
          rresp_d = DECERR;
          state_d = R_RESP;
        end else if (READ_LATENCY == 0) begin
          rdata_d = data_i;
          rresp_d = OKAY;
          state_d = R_RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = data_i;
          rresp_d = OKAY;
          state_d = R_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      R_RESP: begin
        if (rready_i) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read-channel state registers; reset drops any read in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= R_IDLE;
      live_q   <= 1'b0;
      raddr_q  <= '0;
      rrange_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      raddr_q  <= raddr_d;
      rrange_q <= rrange_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_axil_native_bridge.sv
// AXI4-Lite slave to native register-file port bridge for the VGA block.
// Write FSM lives here; the read FSM is in vga_axil_rd_channel.
// Optional feature: define VGA_AXIL_WSTRB_EN to pass byte enables through
// to the native side; otherwise only full-word writes are accepted.
module vga_axil_native_bridge
  import vga_axil_pkg::*;
#(
  parameter int unsigned              AXIL_ADDR_W   = 32,
  parameter int unsigned              AXIL_DATA_W   = 32,
  parameter int unsigned              NATIVE_ADDR_W = 8,
  parameter logic [AXIL_ADDR_W-1:0]   BASE_ADDR     = '0,
  parameter int unsigned              READ_LATENCY  = 1
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [AXIL_ADDR_W-1:0]   awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [AXIL_DATA_W-1:0]   wdata,
  input  logic [AXIL_DATA_W/8-1:0] wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [AXIL_ADDR_W-1:0]   araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [AXIL_DATA_W-1:0]   rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic                     write_en_o,
  output logic [NATIVE_ADDR_W-1:0] addr_write_o,
  output logic [AXIL_DATA_W-1:0]   data_o,
  output logic [AXIL_DATA_W/8-1:0] strb_o,
  output logic                     read_en_o,
  output logic [NATIVE_ADDR_W-1:0] addr_read_o,
  input  logic [AXIL_DATA_W-1:0]   data_i
);

  localparam int unsigned STRB_W    = AXIL_DATA_W / 8;
  localparam int unsigned BYTE_SH   = (AXIL_DATA_W == 64) ? 3 : 2;
  localparam logic [63:0] WIN_BYTES = 64'd1 << (NATIVE_ADDR_W + BYTE_SH);

  axil_wr_state_e           state_q, state_d;
  logic                     live_q;
  logic                     aw_got_q, aw_got_d;
  logic                     w_got_q, w_got_d;
  logic [NATIVE_ADDR_W-1:0] waddr_q, waddr_d;
  logic                     wrange_q, wrange_d;
  logic [AXIL_DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]        wstrb_q, wstrb_d;
  logic                     wr_ok_q, wr_ok_d;
  axil_resp_e               bresp_q, bresp_d;
  logic                     aw_hs, w_hs;
  logic                     strb_ok;

  // Readies depend only on registered state, never on the valids.
  assign awready      = live_q && (state_q == W_IDLE) && !aw_got_q;
  assign wready       = live_q && (state_q == W_IDLE) && !w_got_q;
  assign aw_hs        = awvalid && awready;
  assign w_hs         = wvalid && wready;
  assign write_en_o   = (state_q == W_STROBE) && wr_ok_q;
  assign bvalid       = (state_q == W_RESP);
  assign bresp        = bresp_q;
  assign addr_write_o = waddr_q;
  assign data_o       = wdata_q;

`ifdef VGA_AXIL_WSTRB_EN
  assign strb_ok = 1'b1;
  assign strb_o  = wstrb_q;
`else
  assign strb_ok = (wstrb_d == '1);
  assign strb_o  = '1;
`endif

  // Write FSM next state: collect AW and W in any order, then strobe and respond.
  always_comb begin
    state_d  = state_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    waddr_d  = waddr_q;
    wrange_d = wrange_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wr_ok_d  = wr_ok_q;
    bresp_d  = bresp_q;
    unique case (state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = NATIVE_ADDR_W'((awaddr - BASE_ADDR) >> BYTE_SH);
          wrange_d = addr_in_range(64'(awaddr), 64'(BASE_ADDR), WIN_BYTES);
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        // Both halves may arrive in this very cycle, so decide on the _d values.
        if (aw_got_d && w_got_d) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          state_d  = W_STROBE;
          if (!wrange_d) begin
            wr_ok_d = 1'b0;
            bresp_d = DECERR;
          end else if (!strb_ok) begin
            wr_ok_d = 1'b0;
            bresp_d = SLVERR;
          end else begin
            wr_ok_d = 1'b1;
            bresp_d = OKAY;
          end
        end
      end
      W_STROBE: state_d = W_RESP;
      W_RESP: begin
        if (bready) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Write-channel state registers; reset drops any write in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= W_IDLE;
      live_q   <= 1'b0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      waddr_q  <= '0;
      wrange_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wr_ok_q  <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      waddr_q  <= waddr_d;
      wrange_q <= wrange_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wr_ok_q  <= wr_ok_d;
      bresp_q  <= bresp_d;
    end
  end

  vga_axil_rd_channel #(
    .AXIL_ADDR_W   (AXIL_ADDR_W),
    .AXIL_DATA_W   (AXIL_DATA_W),
    .NATIVE_ADDR_W (NATIVE_ADDR_W),
    .BASE_ADDR     (BASE_ADDR),
    .READ_LATENCY  (READ_LATENCY)
  ) u_rd (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .araddr_i    (araddr),
    .arvalid_i   (arvalid),
    .arready_o   (arready),
    .rdata_o     (rdata),
    .rresp_o     (rresp),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .read_en_o   (read_en_o),
    .addr_read_o (addr_read_o),
    .data_i      (data_i)
  );

endmodule

// File: tb/tb_vga_axil_native_bridge.sv
// Bench for vga_axil_native_bridge: two instances (READ_LATENCY 1 and 3)
// share all AXI inputs; each has its own native register stub.
module tb_vga_axil_native_bridge;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned WIN  = 256 * 4;
`ifdef VGA_AXIL_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready_1, wready_1, bvalid_1, arready_1, rvalid_1, wen_1, ren_1;
  logic [1:0]  bresp_1, rresp_1;
  logic [31:0] rdata_1, wdat_1, din_1;
  logic [7:0]  waddr_1, raddr_1;
  logic [3:0]  strb_1;

  logic        awready_3, wready_3, bvalid_3, arready_3, rvalid_3, wen_3, ren_3;
  logic [1:0]  bresp_3, rresp_3;
  logic [31:0] rdata_3, wdat_3, din_3;
  logic [7:0]  waddr_3, raddr_3;
  logic [3:0]  strb_3;

  vga_axil_native_bridge #(
    .AXIL_ADDR_W(32), .AXIL_DATA_W(32), .NATIVE_ADDR_W(8),
    .BASE_ADDR(BASE), .READ_LATENCY(1)
  ) dut1 (
    .clk_i(clk), .arst_i(arst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_1),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_1),
    .bresp(bresp_1), .bvalid(bvalid_1), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_1),
    .rdata(rdata_1), .rresp(rresp_1), .rvalid(rvalid_1), .rready(rready),
    .write_en_o(wen_1), .addr_write_o(waddr_1), .data_o(wdat_1), .strb_o(strb_1),
    .read_en_o(ren_1), .addr_read_o(raddr_1), .data_i(din_1)
  );

  vga_axil_native_bridge #(
    .AXIL_ADDR_W(32), .AXIL_DATA_W(32), .NATIVE_ADDR_W(8),
    .BASE_ADDR(BASE), .READ_LATENCY(3)
  ) dut3 (
    .clk_i(clk), .arst_i(arst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_3),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_3),
    .bresp(bresp_3), .bvalid(bvalid_3), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_3),
    .rdata(rdata_3), .rresp(rresp_3), .rvalid(rvalid_3), .rready(rready),
    .write_en_o(wen_3), .addr_write_o(waddr_3), .data_o(wdat_3), .strb_o(strb_3),
    .read_en_o(ren_3), .addr_read_o(raddr_3), .data_i(din_3)
  );

  // Native register stubs: data_i is only valid exactly READ_LATENCY cycles
  // after read_en_o, otherwise it carries a poison pattern.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  int since1 = 1000, since3 = 1000;

  function automatic logic [31:0] stub_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (wen_1) mem1[waddr_1] <= stub_merge(mem1[waddr_1], wdat_1, strb_1);
    if (wen_3) mem3[waddr_3] <= stub_merge(mem3[waddr_3], wdat_3, strb_3);
    if (ren_1) since1 <= 0; else if (since1 < 1000) since1 <= since1 + 1;
    if (ren_3) since3 <= 0; else if (since3 < 1000) since3 <= since3 + 1;
  end

  assign din_1 = (since1 == 0) ? mem1[raddr_1] : 32'hBAD0_0001;
  assign din_3 = (since3 == 2) ? mem3[raddr_3] : 32'hBAD0_0003;

  int wen_cnt1 = 0, ren_cnt1 = 0, ren_cnt3 = 0;
  always @(negedge clk) begin
    if (wen_1) wen_cnt1++;
    if (ren_1) ren_cnt1++;
    if (ren_3) ren_cnt3++;
  end

  // Reference model: word-indexed register contents as seen by software.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_get(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(WIN));
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awdly, input int wdly, input string tag);
    bit rng, ok, aw_f, w_f, aw_now, w_now;
    logic [1:0] er;
    logic [31:0] mask;
    int idx, n, c0;
    rng  = in_win(a);
    idx  = int'((a - BASE) >> 2);
    ok   = rng && (STRB_EN || s == 4'hF);
    er   = !rng ? 2'd3 : (ok ? 2'd0 : 2'd2);
    aw_f = 0; w_f = 0; n = 0;
    c0   = wen_cnt1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (awdly == 0);
    wvalid  = (wdly == 0);
    while (!(aw_f && w_f) && n < 20) begin
      aw_now = awvalid && awready_1;
      w_now  = wvalid && wready_1;
      tick();
      n++;
      if (aw_now) begin awvalid = 1'b0; aw_f = 1; end
      if (w_now)  begin wvalid = 1'b0;  w_f = 1;  end
      if (!aw_f && n >= awdly) awvalid = 1'b1;
      if (!w_f && n >= wdly)   wvalid = 1'b1;
    end
    check_eq({tag, ".handshake"}, aw_f && w_f, 1);
    check_eq({tag, ".write_en"}, wen_1, ok);
    if (ok) begin
      check_eq({tag, ".addr_write"}, waddr_1, 64'(idx));
      check_eq({tag, ".data_o"}, wdat_1, d);
      check_eq({tag, ".strb_o"}, strb_1, STRB_EN ? s : 4'hF);
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      if (!STRB_EN) mask = 32'hFFFF_FFFF;
      ref_mem[idx] = (ref_get(idx) & ~mask) | (d & mask);
    end
    tick();
    check_eq({tag, ".bvalid"}, bvalid_1, 1);
    check_eq({tag, ".bresp"}, bresp_1, er);
    check_eq({tag, ".bresp_l3"}, bresp_3, er);
    tick();
    check_eq({tag, ".bvalid_clr"}, bvalid_1, 0);
    check_eq({tag, ".wen_count"}, wen_cnt1 - c0, ok);
  endtask

  task automatic axi_read(input logic [31:0] a, input bit stall, input string tag);
    bit rng, fired;
    logic [1:0] er;
    logic [31:0] exp_d;
    int idx, n, k, k1, k3, c1, c3;
    rng   = in_win(a);
    idx   = int'((a - BASE) >> 2);
    exp_d = rng ? ref_get(idx) : 32'h0;
    er    = rng ? 2'd0 : 2'd3;
    c1 = ren_cnt1; c3 = ren_cnt3;
    araddr = a; arvalid = 1'b1; rready = !stall;
    fired = 0; n = 0;
    while (!fired && n < 20) begin
      fired = arready_1;
      tick();
      n++;
    end
    arvalid = 1'b0;
    check_eq({tag, ".ar_handshake"}, fired, 1);
    check_eq({tag, ".read_en_l1"}, ren_1, rng);
    check_eq({tag, ".read_en_l3"}, ren_3, rng);
    if (rng) check_eq({tag, ".addr_read"}, raddr_1, 64'(idx));
    k = 0; k1 = -1; k3 = -1;
    while ((k1 < 0 || k3 < 0) && k < 20) begin
      tick();
      k++;
      if (k1 < 0 && rvalid_1) begin
        k1 = k;
        check_eq({tag, ".rdata_l1"}, rdata_1, exp_d);
        check_eq({tag, ".rresp_l1"}, rresp_1, er);
      end
      if (k3 < 0 && rvalid_3) begin
        k3 = k;
        check_eq({tag, ".rdata_l3"}, rdata_3, exp_d);
        check_eq({tag, ".rresp_l3"}, rresp_3, er);
      end
    end
    check_eq({tag, ".rvalid_lat_l1"}, k1, rng ? 2 : 1);
    check_eq({tag, ".rvalid_lat_l3"}, k3, rng ? 4 : 1);
    if (stall) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        check_eq({tag, ".hold_rvalid_l1"}, rvalid_1, 1);
        check_eq({tag, ".hold_rdata_l1"}, rdata_1, exp_d);
        check_eq({tag, ".hold_rvalid_l3"}, rvalid_3, 1);
        check_eq({tag, ".hold_rdata_l3"}, rdata_3, exp_d);
      end
      rready = 1'b1;
    end
    tick();
    check_eq({tag, ".rvalid_clr_l3"}, rvalid_3, 0);
    check_eq({tag, ".ren_count_l1"}, ren_cnt1 - c1, rng);
    check_eq({tag, ".ren_count_l3"}, ren_cnt3 - c3, rng);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [31:0] d;
    foreach (mem1[i]) begin mem1[i] = '0; mem3[i] = '0; end
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;

    repeat (3) tick();
    check_eq("rst.awready", awready_1, 0);
    check_eq("rst.wready", wready_1, 0);
    check_eq("rst.arready", arready_1, 0);
    check_eq("rst.bvalid", bvalid_1, 0);
    check_eq("rst.rvalid", rvalid_1, 0);
    check_eq("rst.write_en", wen_1, 0);
    check_eq("rst.read_en", ren_1, 0);
    check_eq("rst.bresp", bresp_1, 0);
    check_eq("rst.rresp", rresp_3, 0);
    check_eq("rst.rdata", rdata_1, 0);
    check_eq("rst.addr_write", waddr_1, 0);
    check_eq("rst.data_o", wdat_1, 0);
    check_eq("rst.addr_read", raddr_3, 0);
    arst = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 10; i++) begin
      idx = int'($urandom_range(0, 255));
      d   = $urandom;
      axi_write(BASE + 32'(idx * 4) + $urandom_range(0, 3), d, 4'hF,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                $sformatf("rnd%0d.wr", i));
      axi_read(BASE + 32'(idx * 4) + $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d.rd", i));
    end

    axi_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 3, 0, "w_first");
    axi_read(BASE + 32'h8, 1'b0, "w_first.rd");
    axi_write(BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 0, 2, "aw_first");
    axi_read(BASE + 32'h20, 1'b0, "aw_first.rd");

    axi_read(BASE + WIN, 1'b0, "rd_above");
    axi_read(BASE - 32'h4, 1'b0, "rd_below");
    axi_write(BASE + WIN, 32'h5555_AAAA, 4'hF, 0, 0, "wr_above");
    axi_read(BASE + 32'h3FC, 1'b0, "rd_last");

    axi_read(BASE + 32'h8, 1'b1, "rd_stall");

    axi_write(BASE + 32'h40, 32'hAABB_CCDD, 4'hF, 0, 0, "strb.pre");
    axi_write(BASE + 32'h40, 32'h1234_5678, 4'b0011, 0, 0, "strb");
    axi_read(BASE + 32'h40, 1'b0, "strb.rd");

    // Reset while a write response is pending.
    bready = 1'b0;
    awaddr = BASE + 32'h10; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    ref_mem[4] = 32'h0BAD_F00D;
    tick();
    check_eq("arst.bvalid_before", bvalid_1, 1);
    #2 arst = 1'b1;
    #1;
    check_eq("arst.bvalid_async", bvalid_1, 0);
    check_eq("arst.bvalid_async_l3", bvalid_3, 0);
    tick();
    tick();
    arst = 1'b0;
    bready = 1'b1;
    tick();
    check_eq("arst.bvalid_after", bvalid_1, 0);
    axi_write(BASE + 32'h14, 32'h0600_D0D0, 4'hF, 0, 0, "post_rst");
    axi_read(BASE + 32'h14, 1'b0, "post_rst.rd");
    axi_read(BASE + 32'h10, 1'b0, "post_rst.rd_pre");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
